// File: rtl/decode_exec_ctrl.sv
// Multi-cycle decode/sequencing controller in front of the ALU.
// Handles one instruction at a time: IDLE -> DECODE -> EXEC -> MEM -> WB.
module decode_exec_ctrl #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  input  logic [15:0]   instr,
  input  logic [DW-1:0] instr_pc,
  output logic          instr_ready,
  output logic [2:0]    alu_opr,
  output logic [DW-1:0] alu_x,
  output logic [DW-1:0] alu_y,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          pc_load,
  output logic [DW-1:0] pc_target,
  output logic          illegal,
  input  logic [2:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

  state_t            state, state_nxt;
  logic [15:0]       ir;
  logic [DW-1:0]     pc_q;
  logic [DW-1:0]     regs [NREG];
  logic [2:0]        opr_q;
  logic [DW-1:0]     x_q, y_q;
  logic [DW-1:0]     mem_addr_q, mem_wdata_q, load_q;

  logic [3:0]        op;
  logic [2:0]        rd, rs, rt;
  logic [DW-1:0]     imm;
  logic              is_mem, wb_we;
  logic [DW-1:0]     wb_data;
  logic [2:0]        dec_opr;
  logic [DW-1:0]     dec_x, dec_y;

  function automatic logic [DW-1:0] sext6(input logic [5:0] v);
    return {{(DW-6){v[5]}}, v};
  endfunction

  assign op     = ir[15:12];
  assign rd     = ir[11:9];
  assign rs     = ir[8:6];
  assign rt     = ir[5:3];
  assign imm    = sext6(ir[5:0]);
  assign is_mem = (op == 4'd10) || (op == 4'd11);

  // Operand selection; illegal and JUMP leave the ALU idle with zero operands
  always_comb begin
    dec_opr = 3'b000;
    dec_x   = '0;
    dec_y   = '0;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
        dec_opr = op[2:0];
        dec_x   = regs[rs];
        dec_y   = regs[rt];
      end
      4'd8:        begin dec_opr = 3'b001; dec_x = regs[rs]; dec_y = imm;      end
      4'd9:        begin dec_opr = 3'b010; dec_x = regs[rd]; dec_y = regs[rs]; end
      4'd10, 4'd11: begin dec_opr = 3'b001; dec_x = regs[rs]; dec_y = imm;      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (instr_valid) state_nxt = DECODE;
      DECODE: begin
        if (op >= 4'd13 || op == 4'd0) state_nxt = IDLE;
        else if (op == 4'd12)          state_nxt = WB;
        else                           state_nxt = EXEC;
      end
      EXEC:   state_nxt = is_mem ? MEM : WB;
      MEM:    if (dmem_ack) state_nxt = WB;
      WB:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wb_we   = (state == WB) && (rd != 3'd0) && ((op <= 4'd8) || (op == 4'd10));
  assign wb_data = (op == 4'd10) ? load_q : alu_result;

  always_comb begin
    pc_load   = 1'b0;
    pc_target = '0;
    if (state == WB) begin
      if (op == 4'd12) begin
        pc_load   = 1'b1;
        pc_target = {pc_q[DW-1:12], ir[11:0]};
      end else if (op == 4'd9 && alu_zero) begin
        pc_load   = 1'b1;
        pc_target = pc_q + DW'(1) + imm;
      end
    end
  end

  assign instr_ready = (state == IDLE);
  assign illegal     = (state == DECODE) && (op >= 4'd13);
  assign dmem_req    = (state == MEM);
  assign dmem_we     = (state == MEM) && (op == 4'd11);
  assign dmem_addr   = mem_addr_q;
  assign dmem_wdata  = mem_wdata_q;
  assign alu_opr     = opr_q;
  assign alu_x       = x_q;
  assign alu_y       = y_q;
  assign dbg_data    = regs[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ir          <= '0;
      pc_q        <= '0;
      opr_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      load_q      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && instr_valid) begin
        ir   <= instr;
        pc_q <= instr_pc;
      end
      if (state == DECODE) begin
        opr_q <= dec_opr;
        x_q   <= dec_x;
        y_q   <= dec_y;
      end
      // Memory address/data are frozen on entry to MEM so they hold across ack waits
      if (state == EXEC && is_mem) begin
        mem_addr_q  <= alu_result;
        mem_wdata_q <= regs[rd];
      end
      if (state == MEM && dmem_ack) load_q <= dmem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_decode_exec_ctrl.sv
// Directed bench for decode_exec_ctrl with a behavioural ALU and a hand-driven memory port.
module tb_decode_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic [15:0] instr_pc = '0;
  logic        instr_ready;
  logic [2:0]  alu_opr;
  logic [15:0] alu_x, alu_y, alu_result;
  logic        alu_zero;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        illegal;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_exec_ctrl #(.DW(16), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .alu_opr(alu_opr), .alu_x(alu_x), .alu_y(alu_y), .alu_result(alu_result), .alu_zero(alu_zero),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pc_load(pc_load), .pc_target(pc_target), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Reference ALU
  always_comb begin
    case (alu_opr)
      3'b001:  alu_result = alu_x + alu_y;
      3'b010:  alu_result = alu_x - alu_y;
      3'b011:  alu_result = alu_x & alu_y;
      3'b100:  alu_result = alu_x | alu_y;
      3'b101:  alu_result = alu_x ^ alu_y;
      3'b110:  alu_result = ~alu_x;
      3'b111:  alu_result = alu_x;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 16'h0000);
  end

  int          pl_cnt = 0;
  int          ill_cnt = 0;
  logic [15:0] last_tgt = '0;
  logic        in_mem = 1'b0;
  logic        m_changed = 1'b0;
  logic [15:0] m_addr = '0, m_wd = '0;
  logic        m_we = 1'b0;
  int          m_cyc = 0;

  always @(negedge clk) begin
    if (pc_load) begin
      pl_cnt   <= pl_cnt + 1;
      last_tgt <= pc_target;
    end
    if (illegal) ill_cnt <= ill_cnt + 1;
    if (dmem_req) begin
      in_mem <= 1'b1;
      if (!in_mem) begin
        m_addr    <= dmem_addr;
        m_wd      <= dmem_wdata;
        m_we      <= dmem_we;
        m_cyc     <= 1;
        m_changed <= 1'b0;
      end else begin
        m_cyc <= m_cyc + 1;
        if (dmem_addr != m_addr || dmem_wdata != m_wd || dmem_we != m_we) m_changed <= 1'b1;
      end
    end else begin
      in_mem <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [15:0] v);
    dbg_addr = a;
    #1 v = dbg_data;
  endtask

  // Issues one instruction, answers the memory port after `waits` stall cycles,
  // and returns the number of clock edges from the accept edge to ready again.
  task automatic run(input logic [15:0] w, input logic [15:0] pc, input int waits,
                     input logic [15:0] rdata, output int lat);
    int mcnt;
    mcnt = 0;
    @(negedge clk);
    instr = w; instr_pc = pc; instr_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    instr_valid = 1'b0;
    while (!instr_ready && lat < 40) begin
      if (dmem_req) begin
        if (mcnt == waits) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdata;
        end
        mcnt++;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      dmem_ack = 1'b0;
    end
  endtask

  initial begin
    int lat, p0, i0, acc;
    logic [15:0] v;

    #2;
    check("rst_ready", instr_ready, 1);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_pc_load", pc_load, 0);
    check("rst_illegal", illegal, 0);
    check("rst_alu_opr", alu_opr, 0);
    check("rst_alu_x", alu_x, 0);
    check("rst_pc_target", pc_target, 0);
    #10 rst_n = 1'b1;

    // ADDI R1, R0, 5
    run(16'h8205, 16'h0000, 0, 16'h0, lat);
    check("addi_lat", lat, 4);
    rd_reg(3'd1, v); check("addi_r1", v, 16'h0005);
    check("addi_opr", alu_opr, 3'b001);
    check("addi_y", alu_y, 16'h0005);

    // ADD R2, R1, R1
    run(16'h1448, 16'h0001, 0, 16'h0, lat);
    check("add_lat", lat, 4);
    rd_reg(3'd2, v); check("add_r2", v, 16'h000A);
    check("add_opr", alu_opr, 3'b001);
    check("add_x", alu_x, 16'h0005);

    // BEQ R2, R2, -2 at 0x0010: taken
    p0 = pl_cnt;
    run(16'h94BE, 16'h0010, 0, 16'h0, lat);
    check("beq_lat", lat, 4);
    check("beq_pulses", pl_cnt - p0, 1);
    check("beq_target", last_tgt, 16'h000F);
    check("beq_opr", alu_opr, 3'b010);

    // BEQ R1, R2, -2: not taken
    p0 = pl_cnt;
    run(16'h92BE, 16'h0020, 0, 16'h0, lat);
    check("bne_pulses", pl_cnt - p0, 0);

    // STORE R2 -> [R1 + 1] with three wait cycles
    run(16'hB441, 16'h0030, 3, 16'h0, lat);
    check("st_lat", lat, 8);
    check("st_addr", m_addr, 16'h0006);
    check("st_wdata", m_wd, 16'h000A);
    check("st_we", m_we, 1);
    check("st_mem_cycles", m_cyc, 4);
    check("st_held", m_changed, 0);

    // LOAD R3 <- [R1 + 1]
    run(16'hA641, 16'h0031, 0, 16'hBEEF, lat);
    check("ld_lat", lat, 5);
    check("ld_we", m_we, 0);
    rd_reg(3'd3, v); check("ld_r3", v, 16'hBEEF);

    // JUMP 0x123 at 0xA000
    p0 = pl_cnt;
    run(16'hC123, 16'hA000, 0, 16'h0, lat);
    check("jmp_lat", lat, 3);
    check("jmp_pulses", pl_cnt - p0, 1);
    check("jmp_target", last_tgt, 16'hA123);

    // Undefined opcode 0xE
    i0 = ill_cnt;
    run(16'hE000, 16'h0040, 0, 16'h0, lat);
    check("ill_lat", lat, 2);
    check("ill_pulses", ill_cnt - i0, 1);
    check("ill_opr", alu_opr, 3'b000);
    rd_reg(3'd1, v); check("ill_r1", v, 16'h0005);
    rd_reg(3'd2, v); check("ill_r2", v, 16'h000A);
    rd_reg(3'd3, v); check("ill_r3", v, 16'hBEEF);

    // ADD R0, R2, R2 must not write R0
    run(16'h1090, 16'h0050, 0, 16'h0, lat);
    check("r0_lat", lat, 4);
    rd_reg(3'd0, v); check("r0_zero", v, 16'h0000);

    // ADDI R4, R4, 1 with instr_valid held high for 12 cycles: three accepts
    acc = 0;
    @(negedge clk);
    instr = 16'h8901; instr_pc = 16'h0060; instr_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (instr_ready && instr_valid) acc++;
      @(posedge clk);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_accepts", acc, 3);
    rd_reg(3'd4, v); check("b2b_r4", v, 16'h0003);

    // Reset while a LOAD waits in MEM
    @(negedge clk);
    instr = 16'hA641; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    for (int k = 0; k < 10 && !dmem_req; k++) @(negedge clk);
    check("mid_mem_req", dmem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_req", dmem_req, 0);
    check("rst_mem_ready", instr_ready, 1);
    check("rst_mem_addr", dmem_addr, 0);
    check("rst_mem_we", dmem_we, 0);
    for (int r = 0; r < 8; r++) begin
      rd_reg(3'(r), v);
      check($sformatf("rst_reg%0d", r), v, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 16'h1234;
    @(negedge clk);
    dmem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_ready", instr_ready, 1);
    check("late_ack_req", dmem_req, 0);
    rd_reg(3'd3, v); check("late_ack_r3", v, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
